xiyiji_param: RTL and testbench
===============================

# xiyiji_param

Parametrised washing-machine sequencer, the next generation of the `xiyiji` controller. It adds four selectable programs, a configurable rinse count, programmable phase durations, timed forward/reverse agitation, and an emergency-stop state. It sits between the front-panel inputs (`select`, `start`, `emergency`) and the actuator/LED drivers. It counts seconds from a prescaled system clock.

## Interface
- `TICK_DIV`, 10: `clk` cycles per one-second tick (≥2).
- `CNT_W`, 6: width of the phase countdown `count`; every phase time must be ≤ 2^CNT_W−1.
- `T_INLET`, 5; `T_DRAIN`, 5; `T_DRY`, 10: phase lengths in ticks (≥1).
- `T_WASH`, 20: standard wash length; heavy uses 2·T_WASH, quick uses T_WASH/2 (floor, min 1).
- `DIR_PERIOD`, 4: ticks per agitation half-cycle (≥1).
- `T_ALARM`, 3: ticks the end-of-cycle alarm is held.

Ports:
- `clk` in 1: system clock, single domain.
- `rst` in 1: synchronous, active-low reset.
- `select` in 1: level; each rising edge in IDLE advances `mode_c`.
- `start` in 1: level; a rising edge starts the program from IDLE.
- `emergency` in 1: active-low emergency stop; 1 = normal.
- `zheng`, `fan` out 1: motor forward / reverse.
- `inlet`, `drain`, `dry` out 1: valve, pump, dryer.
- `alarm` out 1: buzzer.
- `ledzheng`, `ledfan`, `ledinlet`, `leddrain`, `leddry` out 1: equal to the matching actuator.
- `ledstop` out 1: `~zheng & ~fan`.
- `mode_c` out 2: selected program.
- `count` out CNT_W: ticks remaining in the current phase.
- `c_s` out 4: current state encoding, for debug.

## Operation
- Programs (`mode_c`):
  - 0 quick: quick wash, 1 rinse, no dry.
  - 1 standard: T_WASH, 2 rinses, dry.
  - 2 heavy: 2·T_WASH, 3 rinses, dry.
  - 3 dry-only: DRY only.
- States: IDLE, INLET, WASH, DRAIN, RINSE_IN, RINSE, RINSE_DR, DRY, DONE, ESTOP.
- Washing sequence: INLET→WASH→DRAIN. Then, for each rinse, RINSE_IN(T_INLET)→RINSE(T_WASH/2)→RINSE_DR(T_DRAIN). Then DRY if the program has it, then DONE.
- Dry-only sequence: IDLE→DRY→DONE.
- Actuator mapping:
  - `inlet`=1 in INLET and RINSE_IN.
  - `drain`=1 in DRAIN, RINSE_DR and ESTOP.
  - `dry`=1 in DRY.
  - `alarm`=1 in DONE and ESTOP.
  - All actuators are 0 elsewhere.
- Agitation in WASH and RINSE repeats this pattern, restarting at each phase entry:
  - `zheng` for DIR_PERIOD ticks.
  - Stop for 1 tick.
  - `fan` for DIR_PERIOD ticks.
  - Stop for 1 tick.
- `zheng` and `fan` are never both 1.
- `select` edges outside IDLE are ignored. `mode_c` wraps 3→0. `mode_c` is frozen while running.
- An internal rinse counter counts completed rinses. Its width is 2 bits.

## Timing
- Reset values (rst=0 at a clk edge):
  - State IDLE.
  - All actuators, `alarm` and LEDs 0, except `ledstop`=1.
  - `mode_c`=1, `count`=0, prescaler 0.
  - Edge-detector history regs 0.
- Edge detection is registered. A `start` rising edge sampled at edge N moves the state to the first phase at edge N+1.
- Phase entry:
  - `count` loads the phase time.
  - The prescaler clears.
  - Actuators are valid in the same cycle the state is valid. Outputs are registered or decoded from the state register only.
- Tick: the prescaler reaches TICK_DIV−1, giving a one-cycle strobe.
  - On a tick with `count`>1, `count` decrements.
  - On a tick with `count`==1, the next phase is entered.
  - Each phase therefore lasts exactly T·TICK_DIV cycles.
- DONE lasts T_ALARM ticks, then returns to IDLE with `count`=0.
- Emergency: `emergency`=0 sampled in any non-IDLE state enters ESTOP on the next edge. This overrides a simultaneous tick or phase change.
  - In ESTOP: `count`=0 and the rinse counter clears.
  - ESTOP is left to IDLE only when `emergency`=1 and a `start` rising edge occur in the same cycle.
- In IDLE, `emergency`=0 blocks `start`.
- `start` edges while running are ignored, unless the pause feature is compiled in.
- Reset mid-program aborts to IDLE immediately and preserves nothing.

## Configuration
- `XIYIJI_PAUSE_EN` defined:
  - A `start` rising edge in INLET..DRY enters PAUSE. In PAUSE, all actuators are 0, `count` and the prescaler hold, and `alarm`=0.
  - The next `start` edge resumes the saved state with the same agitation position.
  - Emergency still enters ESTOP from PAUSE.
- `XIYIJI_PAUSE_EN` undefined: no PAUSE state, and running `start` edges are ignored.

## Structure
- `xiyiji_pkg` contains:
  - State encoding localparams (4-bit).
  - Mode codes.
  - Per-mode rinse count and dry-enable constants.
  - A function returning the wash time for a mode.
- Sub-module `xiyiji_tick`: the prescaler, with a `clr` input and a `tick` output, parameterised by TICK_DIV.
- The FSM, phase counter, agitation counter and edge detectors live in the top.

## Test plan
All scenarios use TICK_DIV=2, T_INLET=T_DRAIN=2, T_WASH=8, T_DRY=3, DIR_PERIOD=2, T_ALARM=2.
- Reset, then two `select` pulses → `mode_c`=3 (1→2→3). Then `start` → DRY for 6 cycles, DONE for 4 cycles, IDLE.
- Mode 1 full run → total busy cycles = 2·(2+8+2+2·(2+4+2)+3+2) = 66. `zheng`/`fan` pattern in WASH is Z,Z,S,F,F,S,Z,Z ticks.
- Mode 0 → quick wash 4 ticks, exactly one RINSE_IN/RINSE/RINSE_DR, then DONE with no DRY.
- `emergency`=0 mid-WASH → next edge ESTOP with `drain`=1, `alarm`=1, `count`=0. Releasing `emergency` plus a `start` edge → IDLE.
- `rst`=0 during RINSE for one edge → all outputs at reset values, `mode_c`=1.
- With `XIYIJI_PAUSE_EN`: a `start` edge during WASH at `count`=5 → outputs 0 and `count` held at 5 for 20 cycles. A second edge resumes, and WASH finishes 5 ticks later.

Source files
------------

// File: rtl/xiyiji_pkg.sv
// Shared encodings and per-program constants for the xiyiji_param washing-machine sequencer.
// State codes are 4 bits so they can be exported directly on the c_s debug port.
package xiyiji_pkg;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_INLET    = 4'd1;
   localparam logic [3:0] ST_WASH     = 4'd2;
   localparam logic [3:0] ST_DRAIN    = 4'd3;
   localparam logic [3:0] ST_RINSE_IN = 4'd4;
   localparam logic [3:0] ST_RINSE    = 4'd5;
   localparam logic [3:0] ST_RINSE_DR = 4'd6;
   localparam logic [3:0] ST_DRY      = 4'd7;
   localparam logic [3:0] ST_DONE     = 4'd8;
   localparam logic [3:0] ST_ESTOP    = 4'd9;
   localparam logic [3:0] ST_PAUSE    = 4'd10;

   typedef enum logic [3:0] {
      S_IDLE     = ST_IDLE,
      S_INLET    = ST_INLET,
      S_WASH     = ST_WASH,
      S_DRAIN    = ST_DRAIN,
      S_RINSE_IN = ST_RINSE_IN,
      S_RINSE    = ST_RINSE,
      S_RINSE_DR = ST_RINSE_DR,
      S_DRY      = ST_DRY,
      S_DONE     = ST_DONE,
      S_ESTOP    = ST_ESTOP,
      S_PAUSE    = ST_PAUSE
   } state_e;

   localparam logic [1:0] MODE_QUICK = 2'd0;
   localparam logic [1:0] MODE_STD   = 2'd1;
   localparam logic [1:0] MODE_HEAVY = 2'd2;
   localparam logic [1:0] MODE_DRY   = 2'd3;

   localparam logic [1:0] RINSES_QUICK = 2'd1;
   localparam logic [1:0] RINSES_STD   = 2'd2;
   localparam logic [1:0] RINSES_HEAVY = 2'd3;
   localparam logic [1:0] RINSES_DRY   = 2'd0;

   localparam logic DRY_EN_QUICK = 1'b0;
   localparam logic DRY_EN_STD   = 1'b1;
   localparam logic DRY_EN_HEAVY = 1'b1;
   localparam logic DRY_EN_DRY   = 1'b1;

   function automatic logic [1:0] mode_rinses(input logic [1:0] m);
      case (m)
         MODE_QUICK: mode_rinses = RINSES_QUICK;
         MODE_STD:   mode_rinses = RINSES_STD;
         MODE_HEAVY: mode_rinses = RINSES_HEAVY;
         default:    mode_rinses = RINSES_DRY;
      endcase
   endfunction

   function automatic logic mode_dry(input logic [1:0] m);
      case (m)
         MODE_QUICK: mode_dry = DRY_EN_QUICK;
         MODE_STD:   mode_dry = DRY_EN_STD;
         MODE_HEAVY: mode_dry = DRY_EN_HEAVY;
         default:    mode_dry = DRY_EN_DRY;
      endcase
   endfunction

   // Quick (and every rinse) uses half the standard wash, never less than one tick.
   function automatic int wash_time(input logic [1:0] m, input int t_wash);
      int half;
      half = (t_wash / 2 < 1) ? 1 : t_wash / 2;
      case (m)
         MODE_QUICK: wash_time = half;
         MODE_HEAVY: wash_time = 2 * t_wash;
         default:    wash_time = t_wash;
      endcase
   endfunction

endpackage

// File: rtl/xiyiji_param_if.sv
// Front-panel inputs and actuator/LED/debug outputs of the xiyiji_param sequencer.
// The slave modport is the sequencer; the master modport is the panel/driver side.
interface xiyiji_param_if #(
   parameter int CNT_W = 6
);
   logic             select;
   logic             start;
   logic             emergency;
   logic             zheng;
   logic             fan;
   logic             inlet;
   logic             drain;
   logic             dry;
   logic             alarm;
   logic             ledzheng;
   logic             ledfan;
   logic             ledinlet;
   logic             leddrain;
   logic             leddry;
   logic             ledstop;
   logic [1:0]       mode_c;
   logic [CNT_W-1:0] count;
   logic [3:0]       c_s;

   modport master (
      output select, start, emergency,
      input  zheng, fan, inlet, drain, dry, alarm,
      input  ledzheng, ledfan, ledinlet, leddrain, leddry, ledstop,
      input  mode_c, count, c_s
   );

   modport slave (
      input  select, start, emergency,
      output zheng, fan, inlet, drain, dry, alarm,
      output ledzheng, ledfan, ledinlet, leddrain, leddry, ledstop,
      output mode_c, count, c_s
   );
endinterface

// File: rtl/xiyiji_tick.sv
// One-second prescaler: strobes tick for one cycle every TICK_DIV enabled cycles.
// clr restarts the second on phase entry; en low freezes the position.
module xiyiji_tick #(
   parameter int TICK_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int W = $clog2(TICK_DIV);
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/xiyiji_param.sv
// Parametrised washing-machine sequencer: program select, timed phases, agitation, e-stop.
// Define XIYIJI_PAUSE_EN to add a start-toggled PAUSE state during INLET..DRY.
module xiyiji_param
   import xiyiji_pkg::*;
#(
   parameter int TICK_DIV   = 10,
   parameter int CNT_W      = 6,
   parameter int T_INLET    = 5,
   parameter int T_DRAIN    = 5,
   parameter int T_DRY      = 10,
   parameter int T_WASH     = 20,
   parameter int DIR_PERIOD = 4,
   parameter int T_ALARM    = 3
) (
   input logic           clk,
   input logic           rst,
   xiyiji_param_if.slave bus
);
   // Agitation cycle: forward, stop, reverse, stop.
   localparam int AG_N = 2 * DIR_PERIOD + 2;
   localparam int AG_W = $clog2(AG_N);
   localparam logic [AG_W-1:0] AG_LAST = AG_W'(AG_N - 1);
   localparam logic [AG_W-1:0] AG_DIR  = AG_W'(DIR_PERIOD);
   localparam logic [AG_W-1:0] AG_REV  = AG_W'(2 * DIR_PERIOD);

   state_e           state;
   state_e           state_n;
   state_e           dry_next;
   logic [CNT_W-1:0] count;
   logic [AG_W-1:0]  agit_pos;
   logic [1:0]       rinse_cnt;
   logic [1:0]       mode_c;
   logic             start_q;
   logic             start_rise;
   logic             sel_q;
   logic             sel_rise;
   logic             tick;
   logic             phase_end;
   logic             pause_sw;
   logic             agitating;
   logic             pre_clr;
   logic             pre_en;
   logic             zheng;
   logic             fan;

`ifdef XIYIJI_PAUSE_EN
   state_e           saved_state;
`endif

   function automatic logic [CNT_W-1:0] phase_time(input state_e s, input logic [1:0] m);
      case (s)
         S_INLET, S_RINSE_IN: phase_time = CNT_W'(T_INLET);
         S_WASH:              phase_time = CNT_W'(wash_time(m, T_WASH));
         S_RINSE:             phase_time = CNT_W'(wash_time(MODE_QUICK, T_WASH));
         S_DRAIN, S_RINSE_DR: phase_time = CNT_W'(T_DRAIN);
         S_DRY:               phase_time = CNT_W'(T_DRY);
         S_DONE:              phase_time = CNT_W'(T_ALARM);
         default:             phase_time = '0;
      endcase
   endfunction

   xiyiji_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (pre_clr),
      .en   (pre_en),
      .tick (tick)
   );

   assign phase_end = tick && (count == CNT_W'(1));
   assign agitating = (state == S_WASH) || (state == S_RINSE);
   assign dry_next  = mode_dry(mode_c) ? S_DRY : S_DONE;

   // pause_sw is derived without tick so the prescaler enable has no loop through state_n.
   always_comb begin
      pause_sw = 1'b0;
`ifdef XIYIJI_PAUSE_EN
      pause_sw = (state == S_PAUSE) ||
                 (start_rise && bus.emergency && (state inside {[S_INLET:S_DRY]}));
`endif
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:     if (start_rise && bus.emergency)
                        state_n = (mode_c == MODE_DRY) ? S_DRY : S_INLET;
         S_ESTOP:    if (start_rise && bus.emergency) state_n = S_IDLE;
         S_INLET:    if (phase_end) state_n = S_WASH;
         S_WASH:     if (phase_end) state_n = S_DRAIN;
         S_DRAIN:    if (phase_end)
                        state_n = (mode_rinses(mode_c) != 2'd0) ? S_RINSE_IN : dry_next;
         S_RINSE_IN: if (phase_end) state_n = S_RINSE;
         S_RINSE:    if (phase_end) state_n = S_RINSE_DR;
         S_RINSE_DR: if (phase_end)
                        state_n = (rinse_cnt + 2'd1 == mode_rinses(mode_c)) ? dry_next : S_RINSE_IN;
         S_DRY:      if (phase_end) state_n = S_DONE;
         S_DONE:     if (phase_end) state_n = S_IDLE;
`ifdef XIYIJI_PAUSE_EN
         S_PAUSE:    if (start_rise) state_n = saved_state;
`endif
         default:    state_n = S_IDLE;
      endcase
`ifdef XIYIJI_PAUSE_EN
      if (start_rise && (state inside {[S_INLET:S_DRY]})) state_n = S_PAUSE;
`endif
      if ((state != S_IDLE) && !bus.emergency) state_n = S_ESTOP;
   end

   assign pre_clr = ((state_n != state) && !pause_sw) || (state == S_IDLE);
   assign pre_en  = !pause_sw;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         start_q    <= 1'b0;
         start_rise <= 1'b0;
         sel_q      <= 1'b0;
         sel_rise   <= 1'b0;
         mode_c     <= MODE_STD;
      end else begin
         state      <= state_n;
         start_q    <= bus.start;
         start_rise <= bus.start & ~start_q;
         sel_q      <= bus.select;
         sel_rise   <= bus.select & ~sel_q;
         if ((state == S_IDLE) && sel_rise) mode_c <= mode_c + 2'd1;
      end
   end

   // Pausing and resuming keep count and agitation position exactly where they were.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count    <= '0;
         agit_pos <= '0;
      end else if ((state_n == S_ESTOP) || (state_n == S_IDLE)) begin
         count    <= '0;
         agit_pos <= '0;
      end else if (!pause_sw) begin
         if (state_n != state) begin
            count    <= phase_time(state_n, mode_c);
            agit_pos <= '0;
         end else if (tick) begin
            if (count > CNT_W'(1)) count <= count - 1'b1;
            if (agitating) agit_pos <= (agit_pos == AG_LAST) ? '0 : agit_pos + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rinse_cnt <= 2'd0;
      end else if ((state == S_IDLE) || (state_n == S_ESTOP)) begin
         rinse_cnt <= 2'd0;
      end else if ((state == S_RINSE_DR) && phase_end) begin
         rinse_cnt <= rinse_cnt + 2'd1;
      end
   end

`ifdef XIYIJI_PAUSE_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         saved_state <= S_IDLE;
      end else if ((state_n == S_PAUSE) && (state != S_PAUSE)) begin
         saved_state <= state;
      end
   end
`endif

   assign zheng = agitating && (agit_pos < AG_DIR);
   assign fan   = agitating && (agit_pos > AG_DIR) && (agit_pos <= AG_REV);

   assign bus.zheng    = zheng;
   assign bus.fan      = fan;
   assign bus.inlet    = (state == S_INLET) || (state == S_RINSE_IN);
   assign bus.drain    = (state == S_DRAIN) || (state == S_RINSE_DR) || (state == S_ESTOP);
   assign bus.dry      = (state == S_DRY);
   assign bus.alarm    = (state == S_DONE) || (state == S_ESTOP);
   assign bus.ledzheng = zheng;
   assign bus.ledfan   = fan;
   assign bus.ledinlet = bus.inlet;
   assign bus.leddrain = bus.drain;
   assign bus.leddry   = bus.dry;
   assign bus.ledstop  = ~zheng & ~fan;
   assign bus.mode_c   = mode_c;
   assign bus.count    = count;
   assign bus.c_s      = state;

endmodule

// File: tb/tb_xiyiji_param.sv
// Directed bench for xiyiji_param: table of timed panel steps plus whole-program runs.
// Build with XIYIJI_PAUSE_EN defined to exercise the pause sequence.
module tb_xiyiji_param;
  import xiyiji_pkg::*;

  localparam int TICK_DIV   = 2;
  localparam int CNT_W      = 6;
  localparam int T_INLET    = 2;
  localparam int T_DRAIN    = 2;
  localparam int T_DRY      = 3;
  localparam int T_WASH     = 8;
  localparam int DIR_PERIOD = 2;
  localparam int T_ALARM    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xiyiji_param_if #(.CNT_W(CNT_W)) bus ();

  xiyiji_param #(
    .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .T_INLET(T_INLET), .T_DRAIN(T_DRAIN),
    .T_DRY(T_DRY), .T_WASH(T_WASH), .DIR_PERIOD(DIR_PERIOD), .T_ALARM(T_ALARM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One step: drive inputs, let n clock edges pass, then compare everything.
  typedef struct {
    logic       r;
    logic       sel;
    logic       st;
    logic       em;
    int         n;
    logic [3:0] s;
    logic [5:0] c;
    logic [1:0] m;
    logic [5:0] a;  // {zheng, fan, inlet, drain, dry, alarm}
  } vec_t;

  vec_t tbl[38];
  logic [3:0] exp_q[$];
  int vecs = 0;
  int errs = 0;

  function automatic vec_t mk(input logic r, input logic sel, input logic st, input logic em,
                              input int n, input logic [3:0] s, input logic [5:0] c,
                              input logic [1:0] m, input logic [5:0] a);
    vec_t v;
    v.r = r; v.sel = sel; v.st = st; v.em = em; v.n = n;
    v.s = s; v.c = c; v.m = m; v.a = a;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vecs++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [23:0] observed();
    return {bus.c_s, bus.count, bus.mode_c,
            bus.zheng, bus.fan, bus.inlet, bus.drain, bus.dry, bus.alarm,
            bus.ledzheng, bus.ledfan, bus.ledinlet, bus.leddrain, bus.leddry, bus.ledstop};
  endfunction

  task automatic apply_range(input int lo, input int hi);
    logic [23:0] e;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      rst           = tbl[i].r;
      bus.select    = tbl[i].sel;
      bus.start     = tbl[i].st;
      bus.emergency = tbl[i].em;
      repeat (tbl[i].n) @(posedge clk);
      #1;
      e = {tbl[i].s, tbl[i].c, tbl[i].m, tbl[i].a, tbl[i].a[5:1], ~tbl[i].a[5] & ~tbl[i].a[4]};
      check($sformatf("vec%0d", i), 32'(observed()), 32'(e));
    end
  endtask

  // Runs the selected program from IDLE back to IDLE, checking phase order, agitation, length.
  task automatic run_program(input string name, input int exp_busy);
    int busy;
    int phase_cyc;
    int pos;
    logic [3:0] prev;
    logic ez, ef;
    bit done;
    busy = 0; phase_cyc = 0; prev = S_IDLE; done = 0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (bus.c_s != prev) begin
        phase_cyc = 0;
        if (bus.c_s != S_IDLE) begin
          if (exp_q.size() == 0) check({name, "_extra_state"}, 32'(bus.c_s), 32'hF);
          else check({name, "_state"}, 32'(bus.c_s), 32'(exp_q.pop_front()));
        end
        prev = bus.c_s;
      end else begin
        phase_cyc++;
      end
      if (bus.c_s == S_IDLE) begin
        done = 1;
      end else begin
        busy++;
        ez = 1'b0; ef = 1'b0;
        if (bus.c_s == S_WASH || bus.c_s == S_RINSE) begin
          pos = (phase_cyc / TICK_DIV) % (2 * DIR_PERIOD + 2);
          ez  = pos < DIR_PERIOD;
          ef  = (pos > DIR_PERIOD) && (pos <= 2 * DIR_PERIOD);
        end
        check({name, "_agit"}, 32'({bus.zheng, bus.fan}), 32'({ez, ef}));
      end
    end
    check({name, "_finished"}, 32'(done), 32'd1);
    check({name, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
    check({name, "_states_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_state(input string name, input logic [3:0] s, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (bus.c_s == s) hit = 1;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  initial begin
    bus.select    = 1'b0;
    bus.start     = 1'b0;
    bus.emergency = 1'b1;

    // reset, two selects to dry-only, dry-only run, selects back to standard
    tbl[0]  = mk(0, 0, 0, 1, 2, S_IDLE, 0, 1, 6'b000000);
    tbl[1]  = mk(1, 1, 0, 1, 1, S_IDLE, 0, 1, 6'b000000);
    tbl[2]  = mk(1, 0, 0, 1, 1, S_IDLE, 0, 2, 6'b000000);
    tbl[3]  = mk(1, 1, 0, 1, 1, S_IDLE, 0, 2, 6'b000000);
    tbl[4]  = mk(1, 0, 0, 1, 1, S_IDLE, 0, 3, 6'b000000);
    tbl[5]  = mk(1, 0, 1, 1, 1, S_IDLE, 0, 3, 6'b000000);
    tbl[6]  = mk(1, 0, 0, 1, 1, S_DRY, 3, 3, 6'b000010);
    tbl[7]  = mk(1, 0, 0, 1, 2, S_DRY, 2, 3, 6'b000010);
    tbl[8]  = mk(1, 0, 0, 1, 3, S_DRY, 1, 3, 6'b000010);
    tbl[9]  = mk(1, 0, 0, 1, 1, S_DONE, 2, 3, 6'b000001);
    tbl[10] = mk(1, 0, 0, 1, 3, S_DONE, 1, 3, 6'b000001);
    tbl[11] = mk(1, 0, 0, 1, 1, S_IDLE, 0, 3, 6'b000000);
    tbl[12] = mk(1, 1, 0, 1, 1, S_IDLE, 0, 3, 6'b000000);
    tbl[13] = mk(1, 0, 0, 1, 1, S_IDLE, 0, 0, 6'b000000);
    tbl[14] = mk(1, 1, 0, 1, 1, S_IDLE, 0, 0, 6'b000000);
    tbl[15] = mk(1, 0, 0, 1, 1, S_IDLE, 0, 1, 6'b000000);
    // standard -> quick through the wrap
    tbl[16] = mk(1, 1, 0, 1, 1, S_IDLE, 0, 1, 6'b000000);
    tbl[17] = mk(1, 0, 0, 1, 1, S_IDLE, 0, 2, 6'b000000);
    tbl[18] = mk(1, 1, 0, 1, 1, S_IDLE, 0, 2, 6'b000000);
    tbl[19] = mk(1, 0, 0, 1, 1, S_IDLE, 0, 3, 6'b000000);
    tbl[20] = mk(1, 1, 0, 1, 1, S_IDLE, 0, 3, 6'b000000);
    tbl[21] = mk(1, 0, 0, 1, 1, S_IDLE, 0, 0, 6'b000000);
    // emergency mid-WASH, release, and emergency blocking start in IDLE
    tbl[22] = mk(1, 0, 1, 1, 1, S_IDLE, 0, 0, 6'b000000);
    tbl[23] = mk(1, 0, 0, 1, 1, S_INLET, 2, 0, 6'b001000);
    tbl[24] = mk(1, 0, 0, 1, 4, S_WASH, 4, 0, 6'b100000);
    tbl[25] = mk(1, 0, 0, 1, 3, S_WASH, 3, 0, 6'b100000);
    tbl[26] = mk(1, 0, 0, 0, 1, S_ESTOP, 0, 0, 6'b000101);
    tbl[27] = mk(1, 0, 0, 1, 1, S_ESTOP, 0, 0, 6'b000101);
    tbl[28] = mk(1, 0, 1, 1, 1, S_ESTOP, 0, 0, 6'b000101);
    tbl[29] = mk(1, 0, 0, 1, 1, S_IDLE, 0, 0, 6'b000000);
    tbl[30] = mk(1, 0, 1, 0, 1, S_IDLE, 0, 0, 6'b000000);
    tbl[31] = mk(1, 0, 0, 0, 1, S_IDLE, 0, 0, 6'b000000);
    tbl[32] = mk(1, 0, 0, 1, 1, S_IDLE, 0, 0, 6'b000000);
    // reset during RINSE of a quick program
    tbl[33] = mk(1, 0, 1, 1, 1, S_IDLE, 0, 0, 6'b000000);
    tbl[34] = mk(1, 0, 0, 1, 1, S_INLET, 2, 0, 6'b001000);
    tbl[35] = mk(1, 0, 0, 1, 20, S_RINSE, 4, 0, 6'b100000);
    tbl[36] = mk(0, 0, 0, 1, 1, S_IDLE, 0, 1, 6'b000000);
    tbl[37] = mk(1, 0, 0, 1, 1, S_IDLE, 0, 1, 6'b000000);

    apply_range(0, 15);

    exp_q = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    run_program("std", 66);

    apply_range(16, 21);

    exp_q = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8};
    run_program("quick", 36);

    apply_range(22, 32);
    apply_range(33, 37);

`ifdef XIYIJI_PAUSE_EN
    // standard program: pause in WASH at count 5, hold 20 cycles, resume
    begin
      int n;
      bit hit;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (bus.c_s == S_WASH && bus.count == 6'd5) hit = 1;
      end
      check("pause_reach_count5", 32'(hit), 32'd1);
      bus.start = 1'b1;
      @(negedge clk);
      check("pause_pre", 32'({bus.c_s, bus.count}), 32'({S_WASH, 6'd5}));
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        bus.start = 1'b0;
        check($sformatf("pause_hold%0d", i),
              32'({bus.c_s, bus.count, bus.zheng, bus.fan, bus.inlet, bus.drain, bus.dry, bus.alarm}),
              32'({S_PAUSE, 6'd5, 6'b000000}));
      end
      bus.start = 1'b1;
      @(negedge clk);
      check("pause_edge_seen", 32'(bus.c_s), 32'(S_PAUSE));
      @(negedge clk);
      bus.start = 1'b0;
      check("pause_resume", 32'({bus.c_s, bus.count, bus.zheng, bus.fan}),
            32'({S_WASH, 6'd5, 2'b01}));
      n = 1;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
        @(negedge clk);
        if (bus.c_s == S_WASH) n++;
        else hit = 1;
      end
      check("pause_wash_tail", 32'(n), 32'd9);
      check("pause_next_state", 32'(bus.c_s), 32'(S_DRAIN));
      wait_state("pause_back_idle", S_IDLE, 300);
    end
`else
    // standard program: a start edge in WASH must not disturb the run
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_state("run_reach_wash", S_WASH, 100);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("run_start_ignored", 32'({bus.c_s, bus.count}), 32'({S_WASH, 6'd7}));
    wait_state("run_back_idle", S_IDLE, 300);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
